// File: rtl/rx_sd_pkg.sv
// Shared types and width helpers for the multi-channel receive signal detector.
package rx_sd_pkg;

    // Detector FSM states: IDLE/ARM count hits toward assert, DET/HOLD count misses toward deassert.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DET  = 2'd2,
        HOLD = 2'd3
    } sd_state_t;

    // Magnitude needs one bit more than the sample so |min|/2 + |max| never overflows.
    function automatic int mag_width(input int width);
        return width + 1;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n_ch);
        if (n_ch <= 1) begin
            return 1;
        end else begin
            return $clog2(n_ch);
        end
    endfunction

endpackage

// File: rtl/rx_sd_mag.sv
// Per-channel magnitude estimator: exact |I|,|Q| (stage 1), then
// max + min/2 (stage 2). The valid qualifier travels alongside the data.
module rx_sd_mag
    import rx_sd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             i_data,
    input  logic [WIDTH-1:0]             q_data,
    input  logic                         valid_in,
    output logic [mag_width(WIDTH)-1:0]  mag,
    output logic                         valid_out
);

    localparam int MW = mag_width(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] abs_i_s;
    logic [WIDTH-1:0] abs_q_s;
    logic [WIDTH-1:0] abs_i_r;
    logic [WIDTH-1:0] abs_q_r;
    logic [WIDTH-1:0] big_s;
    logic [WIDTH-1:0] small_s;
    logic [MW-1:0]    mag_s;
    logic [MW-1:0]    mag_r;
    logic             valid1_r;
    logic             valid2_r;

    // Two's-complement absolute value read as unsigned, so the most negative code maps to 2^(WIDTH-1).
    always_comb begin
        abs_i_s = i_data[WIDTH-1] ? (~i_data + ONE_W) : i_data;
        abs_q_s = q_data[WIDTH-1] ? (~q_data + ONE_W) : q_data;
    end

    // Stage 1: register the absolute values and their qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_i_r  <= {WIDTH{1'b0}};
            abs_q_r  <= {WIDTH{1'b0}};
            valid1_r <= 1'b0;
        end else begin
            abs_i_r  <= abs_i_s;
            abs_q_r  <= abs_q_s;
            valid1_r <= valid_in;
        end
    end

    // Alpha-max-beta-min estimate with alpha=1, beta=1/2, computed one bit wider than the sample.
    always_comb begin
        if (abs_i_r >= abs_q_r) begin
            big_s   = abs_i_r;
            small_s = abs_q_r;
        end else begin
            big_s   = abs_q_r;
            small_s = abs_i_r;
        end
        mag_s = {1'b0, big_s} + {2'b00, small_s[WIDTH-1:1]};
    end

    // Stage 2: register the magnitude and its qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_r    <= {MW{1'b0}};
            valid2_r <= 1'b0;
        end else begin
            mag_r    <= mag_s;
            valid2_r <= valid1_r;
        end
    end

    assign mag       = mag_r;
    assign valid_out = valid2_r;

endmodule

// File: rtl/rx_sd_multi.sv
// Multi-channel receive signal detector with hysteresis.
// Optional feature macro: RX_SD_PEAK_EN (peak magnitude tracking on SD_peak).
module rx_sd_multi
    import rx_sd_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int N_CH             = 2,
    parameter int MAX_WINDOW_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH:0]                RX_SD_TH_ON,
    input  logic [WIDTH:0]                RX_SD_TH_OFF,
    input  logic [MAX_WINDOW_WIDTH-1:0]   RX_SD_ON_CNT,
    input  logic [MAX_WINDOW_WIDTH-1:0]   RX_SD_OFF_WINDOW,
    input  logic [N_CH*WIDTH-1:0]         I_tdata,
    input  logic [N_CH*WIDTH-1:0]         Q_tdata,
    input  logic                          iq_tvalid,
    output logic                          SD_flag,
    output logic                          SD_rise,
    output logic                          SD_fall,
    output logic [ch_width(N_CH)-1:0]     SD_ch,
    output logic [WIDTH:0]                SD_peak
);

    localparam int MW   = mag_width(WIDTH);
    localparam int CW   = ch_width(N_CH);
    localparam int CNTW = MAX_WINDOW_WIDTH;
    localparam logic [CNTW-1:0] ONE_CNT = {{(CNTW-1){1'b0}}, 1'b1};

    logic [MW-1:0]   mag_s [N_CH];
    logic [N_CH-1:0] ch_valid_s;
    logic            vld_s;

    logic [MW-1:0]   th_off_eff_s;
    logic            hit_s;
    logic            miss_s;
    logic [CW-1:0]   best_ch_s;
    logic [MW-1:0]   best_mag_s;

    logic [CNTW-1:0] on_eff_s;
    logic [CNTW:0]   cnt_inc_s;
    logic [CNTW-1:0] cnt_sat_s;

    sd_state_t       state_r;
    sd_state_t       next_state_s;
    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] next_cnt_s;
    logic            rise_s;
    logic            fall_s;

    logic            flag_r;
    logic            rise_r;
    logic            fall_r;
    logic [CW-1:0]   ch_r;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        rx_sd_mag #(
            .WIDTH (WIDTH)
        ) u_mag (
            .clk       (clk),
            .rst       (rst),
            .i_data    (I_tdata[c*WIDTH +: WIDTH]),
            .q_data    (Q_tdata[c*WIDTH +: WIDTH]),
            .valid_in  (iq_tvalid),
            .mag       (mag_s[c]),
            .valid_out (ch_valid_s[c])
        );
    end

    // Every channel carries the same qualifier; combining them keeps all copies in use.
    assign vld_s = &ch_valid_s;

    // Per-sample decision: hit/miss against live thresholds and the strongest channel (lowest index on ties).
    always_comb begin
        th_off_eff_s = (RX_SD_TH_OFF < RX_SD_TH_ON) ? RX_SD_TH_OFF : RX_SD_TH_ON;
        hit_s        = 1'b0;
        miss_s       = 1'b1;
        best_ch_s    = {CW{1'b0}};
        best_mag_s   = mag_s[0];
        for (int c = 0; c < N_CH; c++) begin
            hit_s  = hit_s  | (mag_s[c] >= RX_SD_TH_ON);
            miss_s = miss_s & (mag_s[c] <  th_off_eff_s);
            if (mag_s[c] > best_mag_s) begin
                best_mag_s = mag_s[c];
                best_ch_s  = CW'(c);
            end else begin
                best_mag_s = best_mag_s;
            end
        end
    end

    // Effective assert count and a saturating increment of the shared counter.
    always_comb begin
        on_eff_s  = (RX_SD_ON_CNT == {CNTW{1'b0}}) ? ONE_CNT : RX_SD_ON_CNT;
        cnt_inc_s = {1'b0, cnt_r} + {{CNTW{1'b0}}, 1'b1};
        cnt_sat_s = (&cnt_r) ? cnt_r : cnt_inc_s[CNTW-1:0];
    end

    // Next-state logic; state and counter only move on qualified samples.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        if (vld_s) begin
            case (state_r)
                IDLE: begin
                    if (hit_s && (on_eff_s == ONE_CNT)) begin
                        next_state_s = DET;
                        next_cnt_s   = {CNTW{1'b0}};
                        rise_s       = 1'b1;
                    end else if (hit_s) begin
                        next_state_s = ARM;
                        next_cnt_s   = ONE_CNT;
                    end else begin
                        next_cnt_s   = {CNTW{1'b0}};
                    end
                end
                ARM: begin
                    if (hit_s && (cnt_inc_s == {1'b0, on_eff_s})) begin
                        next_state_s = DET;
                        next_cnt_s   = {CNTW{1'b0}};
                        rise_s       = 1'b1;
                    end else if (hit_s) begin
                        next_cnt_s   = cnt_sat_s;
                    end else begin
                        next_state_s = IDLE;
                        next_cnt_s   = {CNTW{1'b0}};
                    end
                end
                DET: begin
                    if (miss_s && (RX_SD_OFF_WINDOW == {CNTW{1'b0}})) begin
                        next_state_s = IDLE;
                        next_cnt_s   = {CNTW{1'b0}};
                        fall_s       = 1'b1;
                    end else if (miss_s) begin
                        next_state_s = HOLD;
                        next_cnt_s   = ONE_CNT;
                    end else begin
                        next_cnt_s   = {CNTW{1'b0}};
                    end
                end
                HOLD: begin
                    if (miss_s && (cnt_inc_s >= {1'b0, RX_SD_OFF_WINDOW})) begin
                        next_state_s = IDLE;
                        next_cnt_s   = {CNTW{1'b0}};
                        fall_s       = 1'b1;
                    end else if (miss_s) begin
                        next_cnt_s   = cnt_sat_s;
                    end else begin
                        next_state_s = DET;
                        next_cnt_s   = {CNTW{1'b0}};
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_cnt_s   = {CNTW{1'b0}};
                end
            endcase
        end else begin
            next_state_s = state_r;
            next_cnt_s   = cnt_r;
        end
    end

    // Stage 3: state, counter and registered detector outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNTW{1'b0}};
            flag_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            ch_r    <= {CW{1'b0}};
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            flag_r  <= (next_state_s == DET) || (next_state_s == HOLD);
            rise_r  <= rise_s;
            fall_r  <= fall_s;
            if (rise_s) begin
                ch_r <= best_ch_s;
            end else begin
                ch_r <= ch_r;
            end
        end
    end

`ifdef RX_SD_PEAK_EN
    logic [MW-1:0] peak_r;

    // Peak tracker: load on assert, then keep the running maximum while detected; holds after deassert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_r <= {MW{1'b0}};
        end else if (rise_s) begin
            peak_r <= best_mag_s;
        end else if (vld_s && flag_r && (best_mag_s > peak_r)) begin
            peak_r <= best_mag_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign SD_peak = peak_r;
`else
    assign SD_peak = {MW{1'b0}};
`endif

    assign SD_flag = flag_r;
    assign SD_rise = rise_r;
    assign SD_fall = fall_r;
    assign SD_ch   = ch_r;

endmodule

// File: tb/tb_rx_sd_multi.sv
// Self-checking bench for rx_sd_multi (WIDTH=16, N_CH=2). Directed scenarios
// followed by randomized traffic, compared against a behavioural model that
// tracks "detected" plus a run length of consecutive hits or misses.
module tb_rx_sd_multi;

    localparam int W  = 16;
    localparam int NC = 2;
    localparam int CT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [W:0]      th_on;
    logic [W:0]      th_off;
    logic [CT-1:0]   on_cnt;
    logic [CT-1:0]   off_win;
    logic [NC*W-1:0] i_data;
    logic [NC*W-1:0] q_data;
    logic            valid;
    logic            sd_flag;
    logic            sd_rise;
    logic            sd_fall;
    logic [0:0]      sd_ch;
    logic [W:0]      sd_peak;

    always #5 clk = ~clk;

    rx_sd_multi #(
        .WIDTH            (W),
        .N_CH             (NC),
        .MAX_WINDOW_WIDTH (CT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .RX_SD_TH_ON      (th_on),
        .RX_SD_TH_OFF     (th_off),
        .RX_SD_ON_CNT     (on_cnt),
        .RX_SD_OFF_WINDOW (off_win),
        .I_tdata          (i_data),
        .Q_tdata          (q_data),
        .iq_tvalid        (valid),
        .SD_flag          (sd_flag),
        .SD_rise          (sd_rise),
        .SD_fall          (sd_fall),
        .SD_ch            (sd_ch),
        .SD_peak          (sd_peak)
    );

    typedef struct {
        int i0; int q0; int i1; int q1; bit v;
    } smp_t;

    smp_t sq[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   cfg_on_th, cfg_off_th, cfg_on, cfg_off;
    bit   m_det, m_rise, m_fall;
    int   m_run, m_ch, m_peak;

    function automatic int mag_of(input int i, input int q);
        int a, b;
        a = (i < 0) ? -i : i;
        b = (q < 0) ? -q : q;
        return (a >= b) ? (a + b / 2) : (b + a / 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int a, input int b, input int c, input int d);
        cfg_on_th = a; cfg_off_th = b; cfg_on = c; cfg_off = d;
        th_on   = 17'(a);
        th_off  = 17'(b);
        on_cnt  = 8'(c);
        off_win = 8'(d);
    endtask

    task automatic model_reset();
        smp_t s;
        m_det = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_run = 0; m_ch = 0; m_peak = 0;
        s = '{0, 0, 0, 0, 1'b0};
        sq.delete();
        repeat (3) sq.push_back(s);
    endtask

    // Applies the detector rules to one sample using the configuration in force at its decision edge.
    task automatic model(input smp_t s);
        int m0, m1, mx, arg, off_eff, on_eff;
        bit hit, miss;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s.v) begin
            m0      = mag_of(s.i0, s.q0);
            m1      = mag_of(s.i1, s.q1);
            mx      = (m0 >= m1) ? m0 : m1;
            arg     = (m1 > m0) ? 1 : 0;
            hit     = (m0 >= cfg_on_th) || (m1 >= cfg_on_th);
            off_eff = (cfg_off_th < cfg_on_th) ? cfg_off_th : cfg_on_th;
            miss    = (m0 < off_eff) && (m1 < off_eff);
            on_eff  = (cfg_on == 0) ? 1 : cfg_on;
            if (!m_det) begin
                if (hit) begin
                    m_run++;
                    if (m_run == on_eff) begin
                        m_det = 1'b1; m_rise = 1'b1; m_run = 0; m_ch = arg;
`ifdef RX_SD_PEAK_EN
                        m_peak = mx;
`endif
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
`ifdef RX_SD_PEAK_EN
                if (mx > m_peak) m_peak = mx;
`endif
                if (miss) begin
                    m_run++;
                    if ((cfg_off == 0 && m_run == 1) || (m_run >= 2 && m_run >= cfg_off)) begin
                        m_det = 1'b0; m_fall = 1'b1; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
    endtask

    // One clock: check the decision for the sample driven three edges ago, then drive the next one.
    task automatic step(input int i0, input int q0, input int i1, input int q1, input bit v);
        smp_t s;
        @(posedge clk);
        #1;
        s = sq.pop_front();
        model(s);
        chk("flag", 32'(sd_flag), 32'(m_det));
        chk("rise", 32'(sd_rise), 32'(m_rise));
        chk("fall", 32'(sd_fall), 32'(m_fall));
        chk("ch",   32'(sd_ch),   32'(m_ch));
        chk("peak", 32'(sd_peak), 32'(m_peak));
        s = '{i0, q0, i1, q1, v};
        sq.push_back(s);
        i_data = {16'(i1), 16'(i0)};
        q_data = {16'(q1), 16'(q0)};
        valid  = v;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flag"}, 32'(sd_flag), 32'd0);
        chk({tag, "_rise"}, 32'(sd_rise), 32'd0);
        chk({tag, "_fall"}, 32'(sd_fall), 32'd0);
        chk({tag, "_ch"},   32'(sd_ch),   32'd0);
        chk({tag, "_peak"}, 32'(sd_peak), 32'd0);
    endtask

    function automatic int rnd(input int amp);
        int v;
        v = int'($urandom_range(0, 2 * amp)) - amp;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    initial begin
        int amp;
        rst = 1'b1;
        i_data = '0; q_data = '0; valid = 1'b0;
        set_cfg(1000, 600, 3, 4);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Three hits on channel 1 assert; 800 stays inside the hysteresis band; four zeros deassert.
        repeat (3)  step(0, 0, 1200, 0, 1'b1);
        repeat (10) step(0, 0, 800, 0, 1'b1);
        repeat (4)  step(0, 0, 0, 0, 1'b1);
        repeat (4)  step(0, 0, 0, 0, 1'b1);

        // Hit, hit, miss, hit, hit with a count of three never asserts.
        step(0, 0, 1200, 0, 1'b1);
        step(1100, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 1'b1);
        step(0, 0, 1200, 0, 1'b1);
        step(1300, 0, 0, 0, 1'b1);
        repeat (4) step(0, 0, 0, 0, 1'b1);

        // Most negative I and Q give exactly 49152: the threshold at that value hits, one above does not.
        set_cfg(49152, 600, 1, 4);
        step(-32768, -32768, 0, 0, 1'b1);
        repeat (7) step(0, 0, 0, 0, 1'b1);
        set_cfg(49153, 600, 1, 4);
        step(-32768, -32768, 0, 0, 1'b1);
        repeat (4) step(0, 0, 0, 0, 1'b1);

        // Detected state freezes across a 20-cycle valid gap, then reset lands mid-HOLD.
        set_cfg(1000, 600, 3, 4);
        repeat (5)  step(1500, 0, 1200, 0, 1'b1);
        repeat (20) step(5000, 0, 0, 0, 1'b0);
        repeat (2)  step(0, 0, 0, 0, 1'b1);
        repeat (3)  step(0, 0, 0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Off threshold above on threshold, zero counts: first hit asserts, first sample under 1000 deasserts.
        set_cfg(1000, 2000, 0, 0);
        step(0, 0, 1200, 0, 1'b1);
        step(0, 0, 1500, 0, 1'b1);
        step(0, 0, 999, 0, 1'b1);
        repeat (4) step(0, 0, 0, 0, 1'b1);

        // Randomized traffic with bursty amplitudes and periodically changing live configuration.
        amp = 500;
        for (int n = 0; n < 2000; n++) begin
            if (n % 50 == 0) begin
                set_cfg(int'($urandom_range(500, 3000)), int'($urandom_range(0, 3500)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
            end
            if (n % 8 == 0) begin
                case ($urandom_range(0, 3))
                    0: amp = 300;
                    1: amp = 900;
                    2: amp = 2500;
                    default: amp = 32768;
                endcase
            end
            step(rnd(amp), rnd(amp), rnd(amp), rnd(amp), ($urandom_range(0, 9) < 8));
        end
        repeat (3) step(0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_sd_multi.md
# rx_sd_multi

Multi-channel receive signal detector with hysteresis. It sits after the baseband I/Q decimator and ahead of frame sync, and extends single-channel window detection to N antenna channels. It estimates a per-channel magnitude and applies separate assert/deassert thresholds and counts through a four-state FSM. It reports the detect flag, edge pulses, the strongest channel at acquisition and, optionally, the peak magnitude.

## Interface
- WIDTH, 16, signed I/Q sample width
- N_CH, 2, number of I/Q channel pairs (1..8)
- MAX_WINDOW_WIDTH, 8, width of the count configuration inputs
- clk  in  1  sample-domain clock, 16.384 MHz
- rst  in  1  reset, asynchronous, active-high
- RX_SD_TH_ON  in  WIDTH+1  assert threshold, unsigned magnitude
- RX_SD_TH_OFF  in  WIDTH+1  deassert threshold, unsigned magnitude
- RX_SD_ON_CNT  in  MAX_WINDOW_WIDTH  consecutive valid hits required to assert
- RX_SD_OFF_WINDOW  in  MAX_WINDOW_WIDTH  consecutive valid misses required to deassert
- I_tdata  in  N_CH*WIDTH  packed signed I; channel c occupies bits [c*WIDTH +: WIDTH]
- Q_tdata  in  N_CH*WIDTH  packed signed Q, same packing
- iq_tvalid  in  1  one qualifier for all channels
- SD_flag  out  1  detect flag
- SD_rise  out  1  one-cycle pulse on assert
- SD_fall  out  1  one-cycle pulse on deassert
- SD_ch  out  $clog2(N_CH) (min 1)  strongest channel, latched on assert
- SD_peak  out  WIDTH+1  peak magnitude since the last assert

## Operation
- Absolute value: |x| is exact as WIDTH-bit unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1).
- Magnitude: mag = max(|I|,|Q|) + (min(|I|,|Q|) >> 1), WIDTH+1 bits, no saturation.
- hit: any channel has mag >= RX_SD_TH_ON.
- miss: every channel has mag < TH_OFF_eff, where TH_OFF_eff = min(RX_SD_TH_OFF, RX_SD_TH_ON).
- ON_eff = max(RX_SD_ON_CNT, 1).
- Configuration inputs are read live. A change affects the next sample decision and does not reset the counter.
- FSM states: IDLE, ARM, DET, HOLD. A counter `cnt` (MAX_WINDOW_WIDTH bits) counts only on samples that carry the pipeline valid.
- IDLE:
  - hit and ON_eff==1 → DET
  - hit otherwise → ARM with cnt=1
- ARM:
  - hit → cnt+1; when cnt+1 == ON_eff → DET
  - no hit → IDLE with cnt=0
- DET:
  - miss and RX_SD_OFF_WINDOW==0 → IDLE
  - miss otherwise → HOLD with cnt=1
  - not miss → stay in DET
- HOLD:
  - miss → cnt+1; when cnt+1 >= RX_SD_OFF_WINDOW → IDLE
  - not miss → DET
- Cycles with no valid sample: state and cnt hold in every state.
- SD_flag = state in {DET, HOLD}.
- SD_rise on every transition into DET from IDLE or ARM. SD_fall on every transition into IDLE from DET or HOLD. HOLD→DET produces no pulse.
- SD_ch: index of the largest mag among channels on the entering sample. Ties go to the lowest index. Held until the next assert.
- Counter: saturates and never wraps.

## Timing
- Pipeline: stage 1 registers |I| and |Q|, stage 2 registers mag, stage 3 registers the FSM state and outputs.
- A sample accepted at edge k affects SD_flag, SD_rise, SD_fall and SD_ch after edge k+3.
- Valid bubbles propagate through the pipeline unchanged.
- Reset values: SD_flag=0, SD_rise=0, SD_fall=0, SD_ch=0, SD_peak=0, state=IDLE, cnt=0, pipeline valids=0.
- Reset assertion mid-detection drops SD_flag at once, asynchronously, with no SD_fall pulse.
- A hit and a miss cannot both hold on one sample: miss requires mag < TH_OFF_eff <= TH_ON.

## Configuration
- Macro: RX_SD_PEAK_EN.
- With RX_SD_PEAK_EN defined:
  - SD_peak loads the entering sample's maximum mag on assert.
  - While SD_flag=1, SD_peak updates to max(SD_peak, max mag) on each valid sample. Same stage-3 latency.
  - SD_peak holds after deassert.
- Without it: SD_peak is constant 0 and the peak comparator is not built.

## Structure
- Package rx_sd_pkg:
  - state enum `sd_state_t` {IDLE, ARM, DET, HOLD}
  - constant function for magnitude width (WIDTH+1)
  - constant function for channel-index width
- Sub-module rx_sd_mag: per-channel abs and alpha-max-beta-min with two register stages and valid passthrough, instantiated N_CH times.

## Test plan
- WIDTH=16, N_CH=2, TH_ON=1000, TH_OFF=600, ON_CNT=3, OFF_WINDOW=4. ch1 I=1200 for 3 valid samples → SD_flag=1 and SD_rise pulse 3 cycles after the third sample, SD_ch=1.
- Continue with ch1 mag=800 for 10 samples → SD_flag stays 1 (hysteresis), no SD_fall. Then mag=0 for 4 samples → SD_fall, SD_flag=0 after the fourth plus 3 cycles.
- Hit, hit, miss, hit, hit with ON_CNT=3 → no assert. ARM returns to IDLE on the miss.
- I=-32768, Q=-32768 on ch0 → mag=49152, with no overflow or sign error. With RX_SD_PEAK_EN, SD_peak=49152.
- In DET, deassert iq_tvalid for 20 cycles → state is frozen and no SD_fall. Then assert rst mid-HOLD → SD_flag=0 immediately and all outputs at reset values.
- TH_OFF=2000 > TH_ON=1000, ON_CNT=0, OFF_WINDOW=0 → assert on the first hit, deassert on the first sample with mag < 1000.
